// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave bridge.
// Holds the frame state encoding, the CRC-8 polynomial/initial value and
// the fixed field widths of the SPI frame (command byte, CRC byte).
package spi_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    FETCH,
    DATA,
    CRC,
    DONE
  } state_t;

  localparam logic [7:0]  CRC_POLY  = 8'h1D;
  localparam logic [7:0]  CRC_INIT  = 8'hFF;
  localparam int unsigned CMD_WIDTH = 8;
  localparam int unsigned CRC_WIDTH = 8;
  // Bit counter wide enough for the longest field (32 data bits).
  localparam int unsigned CNT_WIDTH = 6;

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8, MSB first, no reflection, no final XOR.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (state -> CRC_INIT)
//   clr      : synchronous re-initialise to CRC_INIT
//   en       : absorb one message bit this cycle
//   din      : message bit
//   crc      : current CRC state
module crc8_serial
  import spi_slave_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 din,
  output logic [CRC_WIDTH-1:0] crc
);

  logic fb;

  assign fb = crc[CRC_WIDTH-1] ^ din;

  // Galois LFSR step: shift left, fold in the polynomial when the feedback is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC_INIT;
    end else if (clr) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= {crc[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : CRC_WIDTH'(0));
    end
  end

endmodule

// File: rtl/spi_slave_bridge.sv
// SPI mode-0 slave that turns framed transactions into single-word memory
// reads/writes on a synchronous memory port in the clk domain.
// Frame (MSB first): CMD[7:0] (bit7 = write, low ADDR_WIDTH bits = address),
// DATA_WIDTH data bits, then CRC[7:0] when SPI_SLAVE_CRC_EN is defined.
// Build option: `define SPI_SLAVE_CRC_EN to add CRC generation/checking;
// without it the frame has no CRC byte and crc_err is tied low.
// Ports:
//   clk, rst            : system clock, asynchronous active-high reset
//   sck, csn, si        : SPI pins from the pads (synchronised here)
//   so, so_oe           : MISO and its output enable
//   mem_addr/wr/wdata   : memory write port (mem_wr is a 1-clk strobe)
//   mem_rd, mem_rdata   : memory read port, data valid 1 clk after mem_rd
//   frame_done          : pulse when a complete frame ends
//   crc_err, addr_err   : pulses on write CRC mismatch / out-of-range address
//   frame_abort         : pulse when csn rises mid-frame
//   busy                : high while the frame state machine is not idle
module spi_slave_bridge
  import spi_slave_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck,
  input  logic                  csn,
  input  logic                  si,
  output logic                  so,
  output logic                  so_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  frame_done,
  output logic                  crc_err,
  output logic                  addr_err,
  output logic                  frame_abort,
  output logic                  busy
);

  // Pad synchronisers and edge detection.
  logic [SYNC_STAGES-1:0] sck_sync, csn_sync, si_sync;
  logic                   sck_d, csn_d;
  logic                   sck_s, csn_s, si_s;
  logic                   sck_rise, sck_fall, csn_fall, csn_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync <= '0;
      csn_sync <= '1;
      si_sync  <= '0;
      sck_d    <= 1'b0;
      csn_d    <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      csn_sync <= {csn_sync[SYNC_STAGES-2:0], csn};
      si_sync  <= {si_sync[SYNC_STAGES-2:0], si};
      sck_d    <= sck_s;
      csn_d    <= csn_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign csn_s    = csn_sync[SYNC_STAGES-1];
  assign si_s     = si_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign csn_fall = ~csn_s & csn_d;
  assign csn_rise = csn_s & ~csn_d;

  state_t                  state;
  logic [CNT_WIDTH-1:0]    bit_cnt;
  logic [CMD_WIDTH-1:0]    cmd_sh;
  logic [DATA_WIDTH-1:0]   sh;
  logic                    is_wr;
  logic                    addr_oor;
  logic                    fetch_2nd;

  logic                    frame_start;
  logic                    mid_frame;
  logic [CMD_WIDTH-1:0]    cmd_full;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic                    cmd_oor;
  logic                    crc_bad;

  // A new frame may start from IDLE or directly out of DONE (back-to-back).
  assign frame_start = csn_fall && (state == IDLE || state == DONE);
  assign mid_frame   = (state == CMD) || (state == FETCH) || (state == DATA) || (state == CRC);
  assign cmd_full    = {cmd_sh[CMD_WIDTH-2:0], si_s};
  assign cmd_addr    = cmd_full[ADDR_WIDTH-1:0];
  assign cmd_oor     = 32'(cmd_addr) >= DEPTH;

`ifdef SPI_SLAVE_CRC_EN
  logic [CRC_WIDTH-1:0] crc_q;
  logic [CRC_WIDTH-1:0] rx_crc;
  logic                 crc_en;
  logic                 crc_din;

  // CRC covers CMD and DATA; on reads the data bit is the one driven on so.
  assign crc_en  = sck_rise && (state == CMD || state == DATA);
  assign crc_din = (state == DATA && !is_wr) ? so : si_s;
  assign crc_bad = rx_crc != crc_q;

  crc8_serial u_crc (
    .clk (clk),
    .rst (rst),
    .clr (frame_start),
    .en  (crc_en),
    .din (crc_din),
    .crc (crc_q)
  );
`else
  assign crc_bad = 1'b0;
  assign crc_err = 1'b0;
`endif

  // Frame state machine with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      cmd_sh      <= '0;
      sh          <= '0;
      is_wr       <= 1'b0;
      addr_oor    <= 1'b0;
      fetch_2nd   <= 1'b0;
      so          <= 1'b0;
      so_oe       <= 1'b0;
      mem_addr    <= '0;
      mem_wr      <= 1'b0;
      mem_wdata   <= '0;
      mem_rd      <= 1'b0;
      frame_done  <= 1'b0;
      addr_err    <= 1'b0;
      frame_abort <= 1'b0;
      busy        <= 1'b0;
`ifdef SPI_SLAVE_CRC_EN
      rx_crc      <= '0;
      crc_err     <= 1'b0;
`endif
    end else begin
      mem_wr      <= 1'b0;
      mem_rd      <= 1'b0;
      frame_done  <= 1'b0;
      addr_err    <= 1'b0;
      frame_abort <= 1'b0;
`ifdef SPI_SLAVE_CRC_EN
      crc_err     <= 1'b0;
`endif
      so_oe       <= ~csn_s;

      if (csn_rise && mid_frame) begin
        state       <= IDLE;
        busy        <= 1'b0;
        so          <= 1'b0;
        frame_abort <= 1'b1;
      end else begin
        unique case (state)
          IDLE: ;

          CMD: begin
            if (sck_rise) begin
              cmd_sh <= cmd_full;
              if (bit_cnt == CNT_WIDTH'(CMD_WIDTH - 1)) begin
                bit_cnt  <= '0;
                is_wr    <= cmd_full[CMD_WIDTH-1];
                addr_oor <= cmd_oor;
                mem_addr <= cmd_addr;
                sh       <= '0;
                if (cmd_full[CMD_WIDTH-1]) begin
                  state <= DATA;
                end else begin
                  state     <= FETCH;
                  fetch_2nd <= 1'b0;
                  mem_rd    <= ~cmd_oor;
                  addr_err  <= cmd_oor;
                end
              end else begin
                bit_cnt <= bit_cnt + CNT_WIDTH'(1);
              end
            end
          end

          // Cycle 1 carries the mem_rd strobe, cycle 2 captures the returned word.
          FETCH: begin
            if (!fetch_2nd) begin
              fetch_2nd <= 1'b1;
            end else begin
              sh    <= addr_oor ? '0 : mem_rdata;
              state <= DATA;
            end
          end

          DATA: begin
            if (sck_rise) begin
              if (is_wr) sh <= {sh[DATA_WIDTH-2:0], si_s};
              if (bit_cnt == CNT_WIDTH'(DATA_WIDTH - 1)) begin
                bit_cnt <= '0;
`ifdef SPI_SLAVE_CRC_EN
                state   <= CRC;
`else
                state   <= DONE;
                so      <= 1'b0;
`endif
              end else begin
                bit_cnt <= bit_cnt + CNT_WIDTH'(1);
              end
            end else if (sck_fall && !is_wr) begin
              so <= sh[DATA_WIDTH-1];
              sh <= {sh[DATA_WIDTH-2:0], 1'b0};
            end
          end

`ifdef SPI_SLAVE_CRC_EN
          CRC: begin
            if (sck_rise) begin
              if (is_wr) rx_crc <= {rx_crc[CRC_WIDTH-2:0], si_s};
              if (bit_cnt == CNT_WIDTH'(CRC_WIDTH - 1)) begin
                bit_cnt <= '0;
                state   <= DONE;
                so      <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + CNT_WIDTH'(1);
              end
            end else if (sck_fall && !is_wr) begin
              // bit_cnt counts CRC bits already sampled, so ~bit_cnt picks 7 down to 0.
              so <= crc_q[~bit_cnt[2:0]];
            end
          end
`endif

          DONE: begin
            frame_done <= 1'b1;
            if (is_wr) begin
              addr_err <= addr_oor;
`ifdef SPI_SLAVE_CRC_EN
              crc_err  <= crc_bad;
`endif
              if (!addr_oor && !crc_bad) begin
                mem_wr    <= 1'b1;
                mem_wdata <= sh;
              end
            end
            state <= IDLE;
            busy  <= 1'b0;
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase

        // Frame start overrides the DONE -> IDLE return for back-to-back frames.
        if (frame_start) begin
          state   <= CMD;
          busy    <= 1'b1;
          bit_cnt <= '0;
          cmd_sh  <= '0;
          sh      <= '0;
          so      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/spi_slave_bridge.md
Name: spi_slave_bridge

Overview:
Parametrised SPI mode-0 slave that turns framed SPI transactions into single-word read/write accesses on a synchronous memory port.
It is the successor to the fixed 24-bit single-address slave: configurable data width and address space, plus a command byte selecting read or write.
It adds CRC-8 generation and checking, write-commit only on a good CRC, and abort handling.
Its SPI pins come from the chip pads; its memory port connects to a single-port sync RAM or a register bank, all in the clk domain.

Parameters:
DATA_WIDTH, 24, payload bits per frame (8..32)
ADDR_WIDTH, 5, memory address bits (1..7), taken from the low bits of the command byte
DEPTH, 32, number of valid words; an address >= DEPTH is out of range
SYNC_STAGES, 2, synchroniser flops on sck/csn/si (>=2)

Ports:
clk  in  1  system clock; sck must be slower than clk/8
rst  in  1  asynchronous reset, active-high
sck  in  1  SPI clock, idle low
csn  in  1  chip select, active-low
si  in  1  MOSI
so  out  1  MISO
so_oe  out  1  MISO output enable, high while csn is low
mem_addr  out  ADDR_WIDTH  memory address
mem_wr  out  1  one-cycle write strobe
mem_wdata  out  DATA_WIDTH  write data
mem_rd  out  1  one-cycle read strobe; data is returned on mem_rdata exactly 1 clk later
mem_rdata  in  DATA_WIDTH  read data
frame_done  out  1  one-cycle pulse when a complete frame ends
crc_err  out  1  one-cycle pulse when a write-frame CRC mismatches
addr_err  out  1  one-cycle pulse when the address is out of range (no memory access)
frame_abort  out  1  one-cycle pulse when csn rises mid-frame
busy  out  1  high from csn fall until the frame ends

Behaviour:
- Reset: every output 0, state IDLE, CRC register 0xFF, shift registers 0. Reset mid-frame kills the frame silently, with no strobes.
- Inputs pass through SYNC_STAGES flops; sck rise/fall and csn fall/rise are edge-detected in clk.
- Frame, MSB first: CMD[7:0] (bit7 = 1 write, 0 read; bits[ADDR_WIDTH-1:0] = address), then DATA_WIDTH data bits, then CRC[7:0]. Total 16 + DATA_WIDTH sck cycles.
- si is sampled on detected sck rise. so changes on detected sck fall; its first bit is valid by the csn-fall detect.
- CRC-8: polynomial 0x1D, init 0xFF, no reflection, no final XOR, computed over CMD and DATA bits. It is reset to 0xFF at each csn fall.
- State machine: IDLE -> CMD (on csn fall) -> FETCH (after the 8th CMD bit) -> DATA -> CRC -> DONE -> IDLE.
  - FETCH is 2 clk and is skipped for writes.
  - Read, address in range: mem_rd pulses in the FETCH first cycle; mem_rdata is latched into the shift register in the second cycle, before the next sck fall.
  - Read, address out of range: the shift register loads 0 and addr_err pulses.
  - Read: so outputs DATA then the slave-computed CRC. During CMD, so outputs 0.
  - Write: DATA is shifted in from si, and the received CRC byte is compared with the computed CRC.
  - DONE (1 clk): for a write with CRC match and address in range, mem_wr pulses with the latched addr/wdata, in the same cycle as frame_done.
  - DONE, write with CRC mismatch: crc_err pulses and there is no mem_wr. With an address error, addr_err pulses and there is no mem_wr.
- Extra sck edges after CRC and before csn rise are ignored. so holds 0 and state waits in IDLE for csn high.
- csn rise before the last CRC bit: frame_abort pulses, no mem_wr and no frame_done, return to IDLE. so_oe drops on the same clk.
- A csn fall while still in DONE is accepted in the next cycle, so back-to-back frames are supported.
- busy = state != IDLE.

Optional Feature:
SPI_SLAVE_CRC_EN
- Defined: frame as above, with CRC check on writes and CRC generation on reads.
- Undefined: no CRC byte, so the frame is 8 + DATA_WIDTH bits. Writes commit unconditionally if the address is in range. crc_err is tied to 0 and the CRC logic is not instantiated.

Decomposition:
- Package spi_slave_pkg holds:
  - the state enum (IDLE, CMD, FETCH, DATA, CRC, DONE)
  - CRC_POLY = 8'h1D and CRC_INIT = 8'hFF
  - CMD_WIDTH = 8 and CRC_WIDTH = 8
- Sub-module crc8_serial: one bit per enable, with clear input and 8-bit state output. It is instantiated once, with a shared input mux (si for writes, the outgoing so bit for reads).

Test Plan:
- Write, addr 3, data 0xFEDCBA, CRC from the golden model -> mem_wr=1 for 1 clk with mem_addr=3 and mem_wdata=0xFEDCBA; frame_done=1; crc_err=0.
- Same frame with CRC bit0 flipped -> crc_err=1, frame_done=1, mem_wr never asserted.
- Read, addr 0, mem_rdata=0xA5A5A5 -> mem_rd pulses once with addr 0; MISO returns 0xA5A5A5 then the model CRC.
- Read, addr 31 with DEPTH=20 -> addr_err=1, no mem_rd, MISO data=0x000000 followed by the CRC of CMD plus zeros.
- Write with csn raised after 12 bits -> frame_abort=1, no mem_wr, busy=0. The next valid write to addr 1 with 0x123456 commits correctly.
- rst asserted mid-read at bit 20 -> all outputs 0 immediately; after release, a good write with 0x000001 commits.
